id_ex_stage_reg: RTL and testbench
==================================

# id_ex_stage_reg

ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the instruction decoder and captures its control word together with the operands, PC and destination of the decoded instruction. In the EX stage it resolves branches (BEZ/BNE/JMP) and self-flushes the wrong-path instruction following a taken branch. It also handles freeze (stall) and flush (bubble) requests and keeps saturating performance counters.

## Interface
- DATA_W, 32, datapath and PC width
- REG_AW, 5, register-file address width
- CNT_W, 16, performance counter width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_alu_command  in  4  ALU command from decoder
- id_mem_read, id_mem_write, id_wb_enable, id_is_immediate  in  1 each  decoder control bits
- id_branch  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- id_pc  in  DATA_W  PC+4 of the instruction
- id_val1, id_val2  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_dest  in  REG_AW  destination register
- freeze  in  1  hold all state (memory stall / load-use)
- flush  in  1  external bubble request
- ex_valid, ex_mem_read, ex_mem_write, ex_wb_enable  out  1 each  registered control
- ex_alu_command  out  4; ex_branch  out  2; ex_dest  out  REG_AW
- ex_pc, ex_val1, ex_val2  out  DATA_W  registered operands
- ex_alu_b  out  DATA_W  ex_imm when ex_is_immediate else ex_val2
- ex_branch_taken  out  1  branch resolved taken this cycle
- ex_branch_target  out  DATA_W  ex_pc + ex_imm
- bubble_cnt, instr_cnt  out  CNT_W  saturating counters

## Operation
- Update selection each edge, priority order:
  1. bubble = flush | (ex_branch_taken & ~freeze) | (~id_valid & ~freeze);
  2. hold = freeze;
  3. load otherwise.
- Bubble: every registered field is cleared to 0, including ex_valid, all control bits, branch, data and dest.
- Hold: all registers keep their values. ex_branch_taken stays asserted while the frozen branch is held.
- Load: all id_* fields are captured, and ex_valid is set to 1.
- Branch conditions (combinational from registers; all are gated by ex_valid):
  - 01 BEZ: taken when ex_val1 == 0.
  - 10 BNE: taken when ex_val1 != ex_val2.
  - 11 JMP: always taken.
  - 00: never taken.
- Target arithmetic: modulo 2^DATA_W; overflow wraps.
- instr_cnt: +1 on every load with id_valid=1.
- bubble_cnt: +1 on every edge where a bubble is written. A flush while frozen counts as one bubble.
- Both counters saturate at all-ones and never wrap. Neither counter changes on hold.

## Timing
- Reset (asynchronous, rst_n low): all outputs 0, both counters 0. Removal is synchronous to the next edge with no special sequence.
- Latency is 1 cycle: id_* sampled at edge N appear on ex_* after edge N.
- ex_branch_taken, ex_branch_target and ex_alu_b are combinational from registered state, valid in the same cycle as the instruction in EX.
- Taken branch at cycle N: the instruction in ID during cycle N is never loaded; a bubble enters at edge N+1. Upstream flushing of IF/ID is the top level's job.
- flush and freeze in the same cycle: flush wins, and a bubble is written.
- rst_n asserted mid-freeze or mid-branch: state clears immediately, and ex_branch_taken drops asynchronously.

## Structure
- Shared package `mips_pkg`:
  - branch encodings BR_NONE/BR_BEZ/BR_BNE/BR_JMP;
  - 4-bit ALU command constants;
  - DATA_W/REG_AW defaults;
  - packed control-word typedef {alu_command, mem_read, mem_write, wb_enable, is_immediate, branch}.
- One sub-module `branch_cond`: combinational evaluation of ex_branch, ex_val1, ex_val2 and ex_valid, producing taken.
- Everything else stays flat in this module.

## Test plan
- Reset: hold rst_n=0 with arbitrary inputs -> all outputs 0, counters 0. Release, load id_wb_enable=1, id_dest=7 -> next cycle ex_wb_enable=1, ex_dest=7, instr_cnt=1.
- Freeze: load val1=0x11, then freeze 3 cycles while id_* changes -> ex_val1 stays 0x11, counters unchanged. Drop freeze -> new values load.
- BEZ taken: ex_pc=0x100, ex_imm=0x20, ex_val1=0, branch=01 -> ex_branch_taken=1, ex_branch_target=0x120. Next edge writes a bubble, bubble_cnt+1.
- BNE with ex_val1=ex_val2=5 -> not taken, next instruction loads. JMP with freeze=1 -> taken is held for the whole freeze, then a bubble follows.
- Simultaneous flush=1, freeze=1 -> bubble written, ex_valid=0, bubble_cnt+1.
- Saturation: preload via 2^CNT_W+3 flush cycles (CNT_W=4 in the bench) -> bubble_cnt stays 0xF.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings, default widths and the decoded control word.
package mips_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  typedef enum logic [1:0] {BR_NONE = 2'b00, BR_BEZ = 2'b01, BR_BNE = 2'b10, BR_JMP = 2'b11} branch_t;
  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_SLA = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [3:0] ALU_SRL = 4'd10;
  typedef struct packed {
    logic [3:0] alu_command;
    logic       mem_read;
    logic       mem_write;
    logic       wb_enable;
    logic       is_immediate;
    logic [1:0] branch;
  } ctrl_t;
endpackage

// File: rtl/id_ex_stage_reg_if.sv
// id_ex_if: decoder-side inputs and EX-side outputs of the ID/EX register.
interface id_ex_if #(parameter int DATA_W = 32, parameter int REG_AW = 5);
  logic              id_valid;
  logic [3:0]        id_alu_command;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_wb_enable;
  logic              id_is_immediate;
  logic [1:0]        id_branch;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_val1;
  logic [DATA_W-1:0] id_val2;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_dest;
  logic              ex_valid;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_wb_enable;
  logic [3:0]        ex_alu_command;
  logic [1:0]        ex_branch;
  logic [REG_AW-1:0] ex_dest;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_val1;
  logic [DATA_W-1:0] ex_val2;
  logic [DATA_W-1:0] ex_alu_b;
  logic              ex_branch_taken;
  logic [DATA_W-1:0] ex_branch_target;
  modport master (
    output id_valid, id_alu_command, id_mem_read, id_mem_write, id_wb_enable, id_is_immediate,
           id_branch, id_pc, id_val1, id_val2, id_imm, id_dest,
    input  ex_valid, ex_mem_read, ex_mem_write, ex_wb_enable, ex_alu_command, ex_branch, ex_dest,
           ex_pc, ex_val1, ex_val2, ex_alu_b, ex_branch_taken, ex_branch_target
  );
  modport slave (
    input  id_valid, id_alu_command, id_mem_read, id_mem_write, id_wb_enable, id_is_immediate,
           id_branch, id_pc, id_val1, id_val2, id_imm, id_dest,
    output ex_valid, ex_mem_read, ex_mem_write, ex_wb_enable, ex_alu_command, ex_branch, ex_dest,
           ex_pc, ex_val1, ex_val2, ex_alu_b, ex_branch_taken, ex_branch_target
  );
endinterface

// File: rtl/branch_cond.sv
// branch_cond: resolves BEZ/BNE/JMP for the instruction held in EX.
module branch_cond
  import mips_pkg::*;
#(parameter int DATA_W = DEF_DATA_W)
(
  input  logic              valid,
  input  logic [1:0]        branch,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  output logic              taken
);
  assign taken = valid & ((branch == BR_JMP) |
                          ((branch == BR_BEZ) & (val1 == '0)) |
                          ((branch == BR_BNE) & (val1 != val2)));
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with branch resolution, stall/bubble control and perf counters.
module id_ex_stage_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             flush,
  id_ex_if.slave           bus,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] instr_cnt
);
  ctrl_t             ctrl_q, id_ctrl;
  logic              valid_q, taken, bubble;
  logic [DATA_W-1:0] pc_q, val1_q, val2_q, imm_q;
  logic [REG_AW-1:0] dest_q;
  assign id_ctrl = '{alu_command: bus.id_alu_command, mem_read: bus.id_mem_read,
                     mem_write: bus.id_mem_write, wb_enable: bus.id_wb_enable,
                     is_immediate: bus.id_is_immediate, branch: bus.id_branch};
  // a taken branch kills the wrong-path instruction in ID unless stalled; flush overrides freeze
  assign bubble = flush | (~freeze & (taken | ~bus.id_valid));
  branch_cond #(.DATA_W(DATA_W)) u_branch_cond (
    .valid(valid_q), .branch(ctrl_q.branch), .val1(val1_q), .val2(val2_q), .taken(taken)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      val1_q     <= '0;
      val2_q     <= '0;
      imm_q      <= '0;
      dest_q     <= '0;
      bubble_cnt <= '0;
      instr_cnt  <= '0;
    end else if (bubble) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      val1_q     <= '0;
      val2_q     <= '0;
      imm_q      <= '0;
      dest_q     <= '0;
      bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, ~&bubble_cnt};
    end else if (!freeze) begin
      valid_q    <= 1'b1;
      ctrl_q     <= id_ctrl;
      pc_q       <= bus.id_pc;
      val1_q     <= bus.id_val1;
      val2_q     <= bus.id_val2;
      imm_q      <= bus.id_imm;
      dest_q     <= bus.id_dest;
      instr_cnt  <= instr_cnt + {{(CNT_W-1){1'b0}}, ~&instr_cnt};
    end
  end
  assign bus.ex_valid         = valid_q;
  assign bus.ex_mem_read      = ctrl_q.mem_read;
  assign bus.ex_mem_write     = ctrl_q.mem_write;
  assign bus.ex_wb_enable     = ctrl_q.wb_enable;
  assign bus.ex_alu_command   = ctrl_q.alu_command;
  assign bus.ex_branch        = ctrl_q.branch;
  assign bus.ex_dest          = dest_q;
  assign bus.ex_pc            = pc_q;
  assign bus.ex_val1          = val1_q;
  assign bus.ex_val2          = val2_q;
  assign bus.ex_alu_b         = ctrl_q.is_immediate ? imm_q : val2_q;
  assign bus.ex_branch_taken  = taken;
  assign bus.ex_branch_target = pc_q + imm_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed vectors with a scoreboard queue checked by a negedge monitor.
module tb_id_ex_stage_reg;
  import mips_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, freeze = 1'b0, flush = 1'b0;
  logic [3:0] bubble_cnt, instr_cnt;
  int tests = 0, fails = 0;
  id_ex_if #(.DATA_W(32), .REG_AW(5)) bus ();
  id_ex_stage_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .bus(bus),
    .bubble_cnt(bubble_cnt), .instr_cnt(instr_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v, mr, mw, wb, tk;
    logic [3:0] alu;
    logic [1:0] br;
    logic [4:0] dest;
    logic [31:0] pc, v1, v2, alub, tgt;
    logic [3:0] bc, ic;
  } exp_t;
  exp_t q[$];
  exp_t last;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ex_valid", 32'(bus.ex_valid), 32'(e.v));
      chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(e.mr));
      chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(e.mw));
      chk("ex_wb_enable", 32'(bus.ex_wb_enable), 32'(e.wb));
      chk("ex_alu_command", 32'(bus.ex_alu_command), 32'(e.alu));
      chk("ex_branch", 32'(bus.ex_branch), 32'(e.br));
      chk("ex_dest", 32'(bus.ex_dest), 32'(e.dest));
      chk("ex_pc", bus.ex_pc, e.pc);
      chk("ex_val1", bus.ex_val1, e.v1);
      chk("ex_val2", bus.ex_val2, e.v2);
      chk("ex_alu_b", bus.ex_alu_b, e.alub);
      chk("ex_branch_taken", 32'(bus.ex_branch_taken), 32'(e.tk));
      chk("ex_branch_target", bus.ex_branch_target, e.tgt);
      chk("bubble_cnt", 32'(bubble_cnt), 32'(e.bc));
      chk("instr_cnt", 32'(instr_cnt), 32'(e.ic));
    end
  end
  task automatic push(input exp_t e);
    q.push_back(e);
    last = e;
  endtask
  function automatic exp_t zero(input logic [3:0] bc, input logic [3:0] ic);
    exp_t e;
    e = '{default: '0};
    e.bc = bc;
    e.ic = ic;
    return e;
  endfunction
  task automatic set_id(input logic v, input logic [3:0] alu, input logic mr, input logic mw,
                        input logic wb, input logic isi, input logic [1:0] br, input logic [31:0] pc,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                        input logic [4:0] dest);
    bus.id_valid = v; bus.id_alu_command = alu; bus.id_mem_read = mr; bus.id_mem_write = mw;
    bus.id_wb_enable = wb; bus.id_is_immediate = isi; bus.id_branch = br; bus.id_pc = pc;
    bus.id_val1 = v1; bus.id_val2 = v2; bus.id_imm = imm; bus.id_dest = dest;
  endtask
  task automatic step_load(input logic tk, input logic [31:0] tgt, input logic [3:0] bc, input logic [3:0] ic);
    exp_t e;
    e.v = 1'b1; e.mr = bus.id_mem_read; e.mw = bus.id_mem_write; e.wb = bus.id_wb_enable;
    e.alu = bus.id_alu_command; e.br = bus.id_branch; e.dest = bus.id_dest; e.pc = bus.id_pc;
    e.v1 = bus.id_val1; e.v2 = bus.id_val2;
    e.alub = bus.id_is_immediate ? bus.id_imm : bus.id_val2;
    e.tk = tk; e.tgt = tgt; e.bc = bc; e.ic = ic;
    @(posedge clk); #1;
    push(e);
  endtask
  task automatic step_bubble(input logic [3:0] bc, input logic [3:0] ic);
    @(posedge clk); #1;
    push(zero(bc, ic));
  endtask
  task automatic step_hold();
    @(posedge clk); #1;
    push(last);
  endtask
  initial begin
    set_id(1, ALU_SUB, 1, 1, 1, 1, BR_JMP, 32'hDEAD_BEEF, 32'h1234, 32'h5678, 32'h9ABC, 5'd31);
    repeat (2) step_bubble(0, 0);
    rst_n = 1'b1;
    set_id(1, ALU_ADD, 0, 0, 1, 0, BR_NONE, 32'h4, 0, 0, 0, 5'd7);
    step_load(0, 32'h4, 0, 1);
    set_id(1, ALU_OR, 1, 0, 1, 0, BR_NONE, 32'h8, 32'h11, 32'h2, 0, 5'd3);
    step_load(0, 32'h8, 0, 2);
    freeze = 1'b1;
    set_id(1, ALU_AND, 0, 1, 0, 1, BR_NONE, 32'h10, 32'h22, 32'h3, 32'h7, 5'd4);
    repeat (3) step_hold();
    freeze = 1'b0;
    set_id(1, ALU_XOR, 0, 0, 1, 0, BR_NONE, 32'hC, 32'h33, 32'h4, 0, 5'd5);
    step_load(0, 32'hC, 0, 3);
    set_id(1, ALU_NOP, 0, 0, 0, 0, BR_BEZ, 32'h100, 0, 32'h9, 32'h20, 5'd0);
    step_load(1, 32'h120, 0, 4);
    set_id(1, ALU_ADD, 0, 0, 1, 0, BR_NONE, 32'h108, 32'h55, 32'h1, 0, 5'd9);
    step_bubble(1, 4);
    step_load(0, 32'h108, 1, 5);
    set_id(1, ALU_SUB, 0, 0, 0, 1, BR_BNE, 32'h200, 32'h5, 32'h5, 32'h40, 5'd0);
    step_load(0, 32'h240, 1, 6);
    set_id(1, ALU_ADD, 0, 0, 1, 0, BR_NONE, 32'h204, 32'h1, 32'h2, 0, 5'd10);
    step_load(0, 32'h204, 1, 7);
    set_id(1, ALU_NOP, 0, 0, 0, 0, BR_JMP, 32'h300, 0, 0, 32'hFFFF_FF00, 5'd0);
    step_load(1, 32'h200, 1, 8);
    freeze = 1'b1;
    set_id(1, ALU_NOP, 0, 0, 0, 0, BR_BEZ, 32'hFFFF_FFF0, 32'h3, 0, 32'h20, 5'd0);
    repeat (2) step_hold();
    freeze = 1'b0;
    step_bubble(2, 8);
    step_load(0, 32'h10, 2, 9);
    flush = 1'b1; freeze = 1'b1;
    set_id(1, ALU_ADD, 0, 0, 1, 0, BR_NONE, 32'h500, 32'h8, 0, 0, 5'd2);
    step_bubble(3, 9);
    flush = 1'b0; freeze = 1'b0;
    set_id(0, ALU_ADD, 0, 0, 1, 0, BR_NONE, 32'h504, 32'h8, 0, 0, 5'd2);
    step_bubble(4, 9);
    set_id(1, ALU_NOP, 0, 0, 0, 0, BR_JMP, 32'h400, 0, 0, 32'h4, 5'd0);
    step_load(1, 32'h404, 4, 10);
    freeze = 1'b1;
    step_hold();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_taken", 32'(bus.ex_branch_taken), 32'd0);
    chk("async_rst_valid", 32'(bus.ex_valid), 32'd0);
    step_bubble(0, 0);
    rst_n = 1'b1; freeze = 1'b0; flush = 1'b1;
    for (int i = 1; i <= 19; i++) step_bubble(i > 15 ? 4'hF : 4'(i), 0);
    flush = 1'b0;
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
